minisys_soc: RTL and testbench

//  Top-level I/O shell of the Minisys board: 24 switches, 24 LEDs, one UART (rx/tx), program-mode strap start_pg.
//  RUN mode: LEDs show switches XOR a 24-bit mask register. PROG mode: the mask is loaded over UART, 3 bytes per word.

---
 rtl/minisys_pkg.sv | 9 +
 rtl/minisys_uart_rx.sv | 60 ++++++
 rtl/minisys_soc.sv | 124 ++++++++++++
 tb/tb_minisys_soc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/minisys_pkg.sv
// minisys_pkg: shared constants and state types for the Minisys board I/O shell
package minisys_pkg;
    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int LED_W = 24;
    localparam int BYTES_PER_WORD = 3;
    typedef enum logic {RUN, PROG} mode_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
endpackage

// File: rtl/minisys_uart_rx.sv
// minisys_uart_rx: 8N1 UART receiver on an already synchronized line; one-cycle valid / frame_err strobes
module minisys_uart_rx import minisys_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          tick;

    assign tick = cnt == (state == START ? HALF : LAST);

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    // bit timer and LSB-first data shifter
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt  <= '0;
            idx  <= '0;
            data <= '0;
        end else begin
            cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            if (state == IDLE) idx <= '0;
            if (state == DATA && tick) begin
                data <= {rx, data[7:1]};
                idx  <= idx + 1'b1;
            end
        end

    // next state: falling edge, mid-start glitch check, 8 data bits, stop
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rx ? IDLE : START;
            START:   nxt = tick ? (rx ? IDLE : DATA) : START;
            DATA:    nxt = (tick && idx == 3'd7) ? STOP : DATA;
            STOP:    nxt = tick ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end

    // outputs: strobes at the mid-stop sample
    always_comb begin
        valid     = state == STOP && tick && rx;
        frame_err = state == STOP && tick && !rx;
    end
endmodule

// File: rtl/minisys_soc.sv
// minisys_soc: Minisys I/O shell - LEDs show switches XOR mask; mask loaded over UART in PROG mode.
// Optional: MINISYS_UART_ECHO_EN retransmits each accepted PROG byte on tx.
module minisys_soc import minisys_pkg::*; #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             fpga_clk,
    input  logic             fpga_rst,
    input  logic [LED_W-1:0] switch2N4,
    input  logic             start_pg,
    input  logic             rx,
    output logic [LED_W-1:0] led2N4,
    output logic             tx
);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]       rst_q;
    logic             rst_n;
    logic [LED_W-1:0] sw_q, sw_s;
    logic [1:0]       pg_q, rx_q;
    mode_t            mode;
    logic [7:0]       rx_byte;
    logic             rx_valid, unused_frame_err;
    logic [LED_W-1:0] mask, shreg;
    logic [1:0]       cnt;

    // reset asserts asynchronously and releases two clocks after the pin rises
    always_ff @(posedge fpga_clk or negedge fpga_rst)
        if (!fpga_rst) rst_q <= '0;
        else           rst_q <= {rst_q[0], 1'b1};
    assign rst_n = rst_q[1];

    // two-flop synchronizers for the asynchronous board pins
    always_ff @(posedge fpga_clk) begin
        sw_q <= switch2N4;
        sw_s <= sw_q;
        pg_q <= {pg_q[0], start_pg};
        rx_q <= {rx_q[0], rx};
    end
    assign mode = pg_q[1] ? PROG : RUN;

    minisys_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (fpga_clk),
        .rst_n     (rst_n),
        .rx        (rx_q[1]),
        .data      (rx_byte),
        .valid     (rx_valid),
        .frame_err (unused_frame_err)
    );

    // word assembly: shift PROG bytes in, commit every third, drop a partial word in RUN
    always_ff @(posedge fpga_clk or negedge rst_n)
        if (!rst_n) begin
            mask  <= '0;
            shreg <= '0;
            cnt   <= '0;
        end else if (mode == RUN) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (rx_valid) begin
            shreg <= {shreg[LED_W-9:0], rx_byte};
            cnt   <= cnt == LAST_BYTE ? '0 : cnt + 1'b1;
            if (cnt == LAST_BYTE) mask <= {shreg[LED_W-9:0], rx_byte};
        end

    // LED register: word under construction in PROG, masked switches in RUN
    always_ff @(posedge fpga_clk or negedge rst_n)
        if (!rst_n) led2N4 <= '0;
        else        led2N4 <= mode == PROG ? shreg : sw_s ^ mask;

`ifdef MINISYS_UART_ECHO_EN
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TLAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     tstate, tnxt;
    logic [9:0]    frame;
    logic [CW-1:0] tcnt;
    logic [2:0]    nb;
    logic          load, ttick;

    // TX state register
    always_ff @(posedge fpga_clk or negedge rst_n)
        if (!rst_n) tstate <= TX_IDLE;
        else        tstate <= tnxt;

    // TX next state; a byte arriving while busy is simply not echoed
    always_comb begin
        tnxt = tstate;
        case (tstate)
            TX_IDLE:  tnxt = load ? TX_START : TX_IDLE;
            TX_START: tnxt = ttick ? TX_DATA : TX_START;
            TX_DATA:  tnxt = (ttick && nb == 3'd7) ? TX_STOP : TX_DATA;
            TX_STOP:  tnxt = ttick ? TX_IDLE : TX_STOP;
            default:  tnxt = TX_IDLE;
        endcase
    end

    // TX outputs: frame load and bit-period tick
    always_comb begin
        load  = tstate == TX_IDLE && rx_valid && mode == PROG;
        ttick = tstate != TX_IDLE && tcnt == TLAST;
    end

    // frame shifter; tx is its low bit and it refills with idle ones
    always_ff @(posedge fpga_clk or negedge rst_n)
        if (!rst_n) begin
            frame <= '1;
            tcnt  <= '0;
            nb    <= '0;
        end else if (load) begin
            frame <= {1'b1, rx_byte, 1'b0};
            tcnt  <= '0;
            nb    <= '0;
        end else if (ttick) begin
            frame <= {1'b1, frame[9:1]};
            tcnt  <= '0;
            if (tstate == TX_DATA) nb <= nb + 1'b1;
        end else if (tstate != TX_IDLE) begin
            tcnt <= tcnt + 1'b1;
        end
    assign tx = frame[0];
`else
    assign tx = 1'b1;
`endif
endmodule

// File: tb/tb_minisys_soc.sv
// tb_minisys_soc: directed + randomized checks of minisys_soc against a byte-level model
module tb_minisys_soc;
    localparam int C = 8;

    logic        fpga_clk = 1'b0;
    logic        fpga_rst = 1'b0;
    logic [23:0] switch2N4 = '0;
    logic        start_pg = 1'b0;
    logic        rx = 1'b1;
    logic [23:0] led2N4;
    logic        tx;

    int errors = 0;
    int checks = 0;

    logic [23:0] mask_m = '0;
    logic        prog_m = 1'b0;
    logic [7:0]  hist[$];

    always #5 fpga_clk = ~fpga_clk;

    minisys_soc #(.CLKS_PER_BIT(C)) dut (
        .fpga_clk  (fpga_clk),
        .fpga_rst  (fpga_rst),
        .switch2N4 (switch2N4),
        .start_pg  (start_pg),
        .rx        (rx),
        .led2N4    (led2N4),
        .tx        (tx)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge fpga_clk);
        #1;
    endtask

    // PROG shows the last three bytes accepted since entering PROG, RUN shows switches ^ mask
    function automatic logic [23:0] exp_led();
        logic [23:0] v = '0;
        if (!prog_m) return switch2N4 ^ mask_m;
        foreach (hist[i]) v = {v[15:0], hist[i]};
        return v;
    endfunction

    task automatic set_sw(input logic [23:0] v);
        switch2N4 = v;
        cyc(4);
    endtask

    task automatic set_mode(input logic m);
        start_pg = m;
        prog_m = m;
        if (!m) hist.delete();
        cyc(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        int n;
        rx = 1'b0;
        cyc(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(C);
        end
        rx = stop;
        cyc(C);
        rx = 1'b1;
        cyc(C);
        if (stop && prog_m && fpga_rst) begin
            hist.push_back(b);
            n = hist.size();
            if (n % 3 == 0) mask_m = {hist[n-3], hist[n-2], hist[n-1]};
        end
    endtask

    initial begin
        int nb;
        int bad;
        logic [7:0] b;
        logic [9:0] ef;
        switch2N4 = 24'h5a078f;
        cyc(5);
        check("rst_led", led2N4, 24'h0);
        check("rst_tx", 24'(tx), 24'h1);
        fpga_rst = 1'b1;
        cyc(2);
        check("release_led_early", led2N4, 24'h0);
        cyc(1);
        check("release_led_3cyc", led2N4, 24'h5a078f);

        switch2N4 = 24'h00ff00;
        cyc(2);
        check("sw_latency_2", led2N4, 24'h5a078f);
        cyc(1);
        check("sw_latency_3", led2N4, 24'h00ff00);
        set_sw(24'h5a078f);

        set_mode(1'b1);
        check("prog_enter", led2N4, exp_led());
        send_frame(8'h12, 1'b1);
        check("prog_b0", led2N4, 24'h000012);
        send_frame(8'h34, 1'b1);
        check("prog_b1", led2N4, 24'h001234);
        send_frame(8'h56, 1'b1);
        check("prog_b2", led2N4, 24'h123456);
        set_mode(1'b0);
        check("mask_123456", led2N4, 24'h4833d9);

        set_mode(1'b1);
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        check("partial_shown", led2N4, 24'h00aabb);
        set_mode(1'b0);
        check("partial_mask_kept", led2N4, 24'h4833d9);
        set_mode(1'b1);
        check("partial_clean", led2N4, 24'h0);
        send_frame(8'h77, 1'b0);
        check("frame_err_discard", led2N4, 24'h0);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        check("after_frame_err_word", led2N4, 24'h010203);
        set_mode(1'b0);
        check("mask_010203", led2N4, 24'h5a078f ^ 24'h010203);

        set_mode(1'b1);
        cyc(100);
        fork
            send_frame(8'hC3, 1'b1);
            begin
                int n = 0;
`ifdef MINISYS_UART_ECHO_EN
                ef = {1'b1, 8'hC3, 1'b0};
                while (tx !== 1'b0 && n < 200) begin
                    cyc(1);
                    n++;
                end
                check("echo_start", 24'(tx), 24'h0);
                cyc(C / 2);
                for (int i = 0; i < 10; i++) begin
                    check("echo_bit", 24'(tx), 24'(ef[i]));
                    cyc(C);
                end
`else
                ef = '1;
                repeat (200) begin
                    if (tx !== ef[0]) n++;
                    cyc(1);
                end
                check("echo_off_tx_high", 24'(n), 24'h0);
`endif
            end
        join
        set_mode(1'b0);

        for (int k = 0; k < 6; k++) begin
            set_sw(24'($urandom));
            check("rand_run", led2N4, exp_led());
            set_mode(1'b1);
            nb = $urandom_range(1, 5);
            for (int j = 0; j < nb; j++) begin
                bad = $urandom_range(0, 4);
                send_frame(8'($urandom), bad != 0);
                check("rand_prog", led2N4, exp_led());
            end
            set_mode(1'b0);
            check("rand_mask", led2N4, exp_led());
        end

        set_mode(1'b1);
        send_frame(8'($urandom), 1'b1);
        fork
            send_frame(8'($urandom), 1'b1);
            begin
                cyc(30);
                fpga_rst = 1'b0;
                mask_m = '0;
                hist.delete();
                #1;
                check("midbyte_rst_led", led2N4, 24'h0);
                check("midbyte_rst_tx", 24'(tx), 24'h1);
            end
        join
        cyc(3);
        fpga_rst = 1'b1;
        cyc(4);
        check("post_rst_prog", led2N4, exp_led());
        set_mode(1'b0);
        check("post_rst_mask_lost", led2N4, switch2N4);
        set_mode(1'b1);
        for (int j = 0; j < 3; j++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
        end
        set_mode(1'b0);
        check("post_rst_word", led2N4, exp_led());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
